// File: rtl/noise_gen_mc_pkg.sv
// noise_gen_mc shared types, tap constants and amplitude helper.
// Imported by noise_gen_mc and noise_lfsr_ch.
package noise_gen_mc_pkg;

    typedef enum logic {
        RUN,
        SEED
    } state_e;

    // Middle taps sit at W/2 and W/3 alongside the MSB and LSB.
    localparam int TAP_MID_DIV = 2;
    localparam int TAP_LOW_DIV = 3;

    function automatic int keep_bits(
        input int sel,
        input int w,
        input int sel_w
    );
        return w - 2 * ((2 ** sel_w - 1) - sel);
    endfunction

endpackage

// File: rtl/noise_lfsr_ch.sv
// One Fibonacci LFSR channel with seed load.
// A zero load value is replaced by all-ones so the LFSR never locks up.
module noise_lfsr_ch
    import noise_gen_mc_pkg::*;
#(
    parameter int             W       = 24,
    parameter logic [W-1:0]   RST_VAL = '1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         adv_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic [W-1:0] state_o
);

    logic [W-1:0] state_q;
    logic [W-1:0] state_d;
    logic         fb;

    assign fb = state_q[W-1] ^ state_q[W/TAP_MID_DIV]
              ^ state_q[W/TAP_LOW_DIV] ^ state_q[0];

    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = (load_val_i == '0) ? '1 : load_val_i;
        end else if (adv_i) begin
            state_d = {state_q[W-2:0], fb};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= RST_VAL;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/noise_gen_mc.sv
// Multi-channel LFSR noise source with amplitude select and seed reload.
// Define NOISE_GEN_MC_SIGNED_EN for zero-mean two's-complement lanes.
module noise_gen_mc
    import noise_gen_mc_pkg::*;
#(
    parameter int LFSR_WIDTH = 24,
    parameter int NUM_CH     = 4,
    parameter int SEL_W      = 2
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_en,
    input  logic [SEL_W-1:0]             i_sel,
    input  logic                         i_seed_load,
    input  logic [LFSR_WIDTH-1:0]        i_seed,
    input  logic                         i_ready,
    output logic                         o_valid,
    output logic [NUM_CH*LFSR_WIDTH-1:0] o_noise,
    output logic                         o_busy
);

    localparam int W     = LFSR_WIDTH;
    localparam int CNT_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    state_e                state_q;
    logic [W-1:0]          seed_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  valid_q;
    logic                  busy_q;
    logic [NUM_CH*W-1:0]   noise_q;
    logic [NUM_CH*W-1:0]   noise_d;
    logic                  load;
    logic [W-1:0]          ch_s [NUM_CH];

    // A seed pulse pre-empts a load in the same cycle.
    assign load = (state_q == RUN) && i_en
               && (!valid_q || i_ready) && !i_seed_load;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic ld;
        assign ld = (state_q == SEED) && (cnt_q == CNT_W'(c));

        noise_lfsr_ch #(
            .W       (W),
            .RST_VAL ({W{1'b1}} ^ W'(c))
        ) u_ch (
            .clk_i      (i_clk),
            .rst_i      (i_rst),
            .adv_i      (load),
            .load_i     (ld),
            .load_val_i (seed_q ^ W'(c)),
            .state_o    (ch_s[c])
        );
    end

    always_comb begin
        int   k;
        logic sgn;
        k       = keep_bits(int'(i_sel), W, SEL_W);
        noise_d = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            sgn = 1'b0;
            for (int b = 0; b < W; b++) begin
                if (b == k - 1) sgn = ch_s[c][b];
            end
            for (int b = 0; b < W; b++) begin
`ifdef NOISE_GEN_MC_SIGNED_EN
                if (b < k - 1) noise_d[c*W+b] = ch_s[c][b];
                else           noise_d[c*W+b] = ~sgn;
`else
                if (b < k)     noise_d[c*W+b] = ch_s[c][b];
`endif
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= RUN;
            seed_q  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            noise_q <= '0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (i_seed_load) begin
                        state_q <= SEED;
                        seed_q  <= i_seed;
                        cnt_q   <= '0;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end else if (load) begin
                        valid_q <= 1'b1;
                        noise_q <= noise_d;
                    end else if (valid_q && i_ready) begin
                        valid_q <= 1'b0;
                    end
                end
                SEED: begin
                    if (cnt_q == CNT_W'(NUM_CH - 1)) begin
                        state_q <= RUN;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

    assign o_valid = valid_q;
    assign o_noise = noise_q;
    assign o_busy  = busy_q;

endmodule

// File: tb/tb_noise_gen_mc.sv
// Scoreboard bench for noise_gen_mc (W=24, NUM_CH=4, SEL_W=2).
// Build with NOISE_GEN_MC_SIGNED_EN to check signed lanes.
module tb_noise_gen_mc;

    localparam int W  = 24;
    localparam int NC = 4;
    localparam int SW = 2;

`ifdef NOISE_GEN_MC_SIGNED_EN
    localparam logic [23:0] S3 = 24'h800000;
    localparam logic [95:0] BM = {24'h01FFFC, 24'h01FFFD,
                                  24'h01FFFE, 24'h01FFFF};
    localparam logic [95:0] BS = {24'h800002, 24'h800003,
                                  24'h7FFFFF, 24'h800001};
`else
    localparam logic [23:0] S3 = 24'h000000;
    localparam logic [95:0] BM = {24'h03FFFC, 24'h03FFFD,
                                  24'h03FFFE, 24'h03FFFF};
    localparam logic [95:0] BS = {24'h000002, 24'h000003,
                                  24'hFFFFFF, 24'h000001};
`endif
    localparam logic [95:0] B0 = {24'hFFFFFC ^ S3, 24'hFFFFFD ^ S3,
                                  24'hFFFFFE ^ S3, 24'hFFFFFF ^ S3};
    localparam logic [95:0] B1 = {24'hFFFFF9 ^ S3, 24'hFFFFFA ^ S3,
                                  24'hFFFFFD ^ S3, 24'hFFFFFE ^ S3};

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [SW-1:0] sel;
    logic          seed_load;
    logic [W-1:0]  seed;
    logic          ready;
    logic          valid;
    logic [95:0]   noise;
    logic          busy;

    logic [95:0]   q[$];
    logic [95:0]   exp_w;
    int            total = 0;
    int            bad   = 0;

    always #5 clk = ~clk;

    noise_gen_mc #(
        .LFSR_WIDTH (W),
        .NUM_CH     (NC),
        .SEL_W      (SW)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_en        (en),
        .i_sel       (sel),
        .i_seed_load (seed_load),
        .i_seed      (seed),
        .i_ready     (ready),
        .o_valid     (valid),
        .o_noise     (noise),
        .o_busy      (busy)
    );

    task automatic chk(input string n, input logic [95:0] got,
                       input logic [95:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", n, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && valid && ready) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL beat: got %h want none", noise);
            end else begin
                exp_w = q.pop_front();
                chk("beat", noise, exp_w);
            end
        end
    end

    initial begin
        rst = 1'b1; en = 1'b0; sel = 2'd3;
        seed_load = 1'b0; seed = '0; ready = 1'b0;
        tick(); tick(); tick();
        chk("rst_valid", valid, 0);
        chk("rst_noise", noise, 0);
        chk("rst_busy", busy, 0);

        // first and second beat
        rst = 1'b0; en = 1'b1; ready = 1'b1;
        q.push_back(B0);
        tick();
        chk("lat_valid", valid, 1);
        q.push_back(B1);
        tick();
        en = 1'b0;
        tick();
        chk("drain_valid", valid, 0);

        // amplitude mask
        rst = 1'b1; tick();
        rst = 1'b0; sel = 2'd0; en = 1'b1;
        q.push_back(BM);
        tick();
        en = 1'b0;
        tick();

        // backpressure
        rst = 1'b1; tick();
        rst = 1'b0; sel = 2'd3; en = 1'b1; ready = 1'b0;
        q.push_back(B0);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("hold_noise", noise, B0);
            tick();
        end
        chk("hold_valid", valid, 1);
        ready = 1'b1;
        q.push_back(B1);
        tick();
        chk("replace_valid", valid, 1);
        en = 1'b0;
        tick();

        // seed reload; seed pulse beats a qualifying load
        en = 1'b1; ready = 1'b0;
        seed_load = 1'b1; seed = 24'h000001;
        tick();
        seed_load = 1'b0; seed = 24'hABCDEF;
        for (int i = 0; i < 4; i++) begin
            chk("seed_busy", busy, 1);
            chk("seed_valid", valid, 0);
            tick();
        end
        chk("seed_done", busy, 0);
        chk("seed_noload", valid, 0);
        q.push_back(BS);
        tick();
        chk("seed_beat_v", valid, 1);
        ready = 1'b1; en = 1'b0;
        tick();

        // reset in the middle of a reload
        seed_load = 1'b1; seed = 24'h123456;
        tick();
        seed_load = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        chk("mid_busy", busy, 0);
        chk("mid_valid", valid, 0);
        rst = 1'b0; en = 1'b1; sel = 2'd3;
        q.push_back(B0);
        tick();
        q.push_back(B1);
        tick();
        en = 1'b0;
        tick(); tick();
        chk("queue_empty", 96'(q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
